// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder/subtractor, one 4-bit slice per clock LSB first; done pulses NIBBLES cycles after start.
// No backpressure: start is honoured only in IDLE and dropped while busy; results hold until the next completion.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   Sub,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Cout,
    output logic                   Ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_sum;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;

    logic [4:0]      w_slice;
    logic [3:0]      w_lo;
    logic            w_c3;
    logic            w_last;
    logic [W+3:0]    w_work_cat;
    logic [W+3:0]    w_a_cat;
    logic [W+3:0]    w_b_cat;

    // Slice adder; the carry into bit 3 is kept for the overflow flag on the top slice.
    assign w_slice    = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
    assign w_lo       = {1'b0, r_a[2:0]} + {1'b0, r_b[2:0]} + {3'b0, r_carry};
    assign w_c3       = w_lo[3];
    assign w_last     = (r_cnt == CW'(NIBBLES - 1));
    assign w_work_cat = {w_slice[3:0], r_work};
    assign w_a_cat    = {4'b0, r_a};
    assign w_b_cat    = {4'b0, r_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operands shift right so the active slice is always bits [3:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= Sub ? ~B : B;
                        r_carry <= Sub ? 1'b1 : Cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_cat[W+3:4];
                    r_b     <= w_b_cat[W+3:4];
                    r_work  <= w_work_cat[W+3:4];
                    r_carry <= w_slice[4];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum  <= w_work_cat[W+3:4];
                        r_cout <= w_slice[4];
                        r_ovf  <= w_c3 ^ w_slice[4];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed table, handshake corner cases, reset, and random ops on 4- and 1-nibble builds.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        start4, sub4, cin4;
    logic [15:0] a4, b4;
    logic        busy4, done4, cout4, ovf4;
    logic [15:0] sum4;
    logic        start1, sub1, cin1;
    logic [3:0]  a1, b1;
    logic        busy1, done1, cout1, ovf1;
    logic [3:0]  sum1;

    int errors;
    int checks;
    bit sel;
    logic        m_busy, m_done, m_cout, m_ovf;
    logic [15:0] m_sum;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .Sub(sub4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4), .Ovf(ovf4)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .Sub(sub1), .A(a1), .B(b1), .Cin(cin1),
        .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        m_busy = sel ? busy1 : busy4;
        m_done = sel ? done1 : done4;
        m_cout = sel ? cout1 : cout4;
        m_ovf  = sel ? ovf1  : ovf4;
        m_sum  = sel ? {12'h000, sum1} : sum4;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic cin,
                                  output logic [15:0] s, output logic c, output logic o);
        logic [16:0] mask;
        logic [16:0] aa;
        logic [16:0] bb;
        logic [16:0] r;
        mask = (17'd1 << w) - 17'd1;
        aa   = {1'b0, a} & mask;
        bb   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        r    = aa + bb + (sub ? 17'd1 : {16'd0, cin});
        c    = r[w];
        s    = r[15:0] & mask[15:0];
        o    = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    endfunction

    // Called #1 after a rising edge with the selected DUT idle; returns #1 after the edge that retires it to IDLE.
    task automatic run_op(input bit s, input logic [15:0] a, input logic [15:0] b,
                          input logic sb, input logic ci, input logic [15:0] es,
                          input logic ec, input logic eo, input string tag);
        int n;
        int lat;
        int busy_cnt;
        sel = s;
        n   = s ? 1 : 4;
        if (s) begin
            a1 = a[3:0]; b1 = b[3:0]; sub1 = sb; cin1 = ci; start1 = 1'b1;
        end else begin
            a4 = a; b4 = b; sub4 = sb; cin4 = ci; start4 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        a4 = 16'($urandom); b4 = 16'($urandom); sub4 = ~sb; cin4 = ~ci;
        a1 = 4'($urandom);  b1 = 4'($urandom);  sub1 = ~sb; cin1 = ~ci;
        lat = 0;
        busy_cnt = m_busy ? 1 : 0;
        while (!m_done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (m_busy) busy_cnt++;
        end
        chk({tag, " latency"}, lat, n);
        chk({tag, " Sum"}, m_sum, es);
        chk({tag, " Cout"}, m_cout, ec);
        chk({tag, " Ovf"}, m_ovf, eo);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, m_done, 1'b0);
        chk({tag, " busy dropped"}, m_busy, 1'b0);
        chk({tag, " busy cycles"}, busy_cnt, n + 1);
        chk({tag, " Sum held"}, m_sum, es);
    endtask

    initial begin
        vec_t        tbl[8];
        logic [15:0] es;
        logic        ec, eo;
        int          done_cnt;
        logic [15:0] ra, rb;
        logic        rs, rc;

        tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
        tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        errors = 0; checks = 0; sel = 1'b0;
        start4 = 0; sub4 = 0; cin4 = 0; a4 = 0; b4 = 0;
        start1 = 0; sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy4, 1'b0);
        chk("reset done", done4, 1'b0);
        chk("reset Sum", sum4, 16'h0000);
        chk("reset Cout", cout4, 1'b0);
        chk("reset Ovf", ovf4, 1'b0);
        chk("reset busy n1", busy1, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_op(1'b0, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
                   tbl[i].sum, tbl[i].cout, tbl[i].ovf, $sformatf("vec%0d", i));

        // Start held through RUN and DONE with different operands: only the first is taken,
        // then the still-high start is accepted in the first IDLE cycle.
        sel = 1'b0;
        a4 = 16'h1111; b4 = 16'h2222; sub4 = 0; cin4 = 0; start4 = 1'b1;
        @(posedge clk); #1;
        a4 = 16'hFFFF; b4 = 16'hFFFF;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (done4) done_cnt++;
        end
        chk("held start done at 4", done4, 1'b1);
        chk("held start Sum", sum4, 16'h3333);
        @(posedge clk); #1;
        if (done4) done_cnt++;
        chk("held start one done", done_cnt, 1);
        chk("held start idle busy", busy4, 1'b0);
        @(posedge clk); #1;
        chk("first idle start accepted", busy4, 1'b1);
        start4 = 1'b0;
        for (int c = 0; c < 8 && !done4; c++) begin
            @(posedge clk); #1;
        end
        chk("second op done", done4, 1'b1);
        chk("second op Sum", sum4, 16'hFFFE);
        chk("second op Cout", cout4, 1'b1);
        chk("second op Ovf", ovf4, 1'b0);
        @(posedge clk); #1;

        // Reset at the second RUN edge discards the operation.
        a4 = 16'h0F0F; b4 = 16'h0101; sub4 = 0; cin4 = 0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun rst busy", busy4, 1'b0);
        chk("midrun rst done", done4, 1'b0);
        chk("midrun rst Sum", sum4, 16'h0000);
        chk("midrun rst Cout", cout4, 1'b0);
        chk("midrun rst Ovf", ovf4, 1'b0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done4) done_cnt++;
        end
        chk("midrun rst no done", done_cnt, 0);
        run_op(1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, "after rst");

        // Reset wins over start on the same edge.
        rst = 1'b1; start4 = 1'b1; a4 = 16'h0001; b4 = 16'h0001;
        @(posedge clk); #1;
        rst = 1'b0; start4 = 1'b0;
        chk("rst over start busy", busy4, 1'b0);
        @(posedge clk); #1;
        chk("rst over start stays idle", busy4, 1'b0);

        run_op(1'b1, 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "n1 F+1");
        run_op(1'b1, 16'h0007, 16'h0001, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b1, "n1 7+1");
        run_op(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b0, 16'h000E, 1'b0, 1'b0, "n1 3-5");

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            model(4, ra, rb, rs, rc, es, ec, eo);
            run_op(1'b1, ra, rb, rs, rc, es, ec, eo, $sformatf("rand1 %0d", i));
        end

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            model(16, ra, rb, rs, rc, es, ec, eo);
            run_op(1'b0, ra, rb, rs, rc, es, ec, eo, $sformatf("rand4 %0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
